// File: rtl/bcd_display_pkg.sv
// ============================================================================
// Module      : bcd_display_pkg
// Description : Shared 7-segment types and glyph constants for the
//               counter/display design. Bit order is {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_display_pkg;

    // Bit 0 = segment a ... bit 6 = segment g, active-high.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;

endpackage

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to 7-segment decoder; codes 10-15 show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bcd_scan_display.sv
// ============================================================================
// Module      : bcd_scan_display
// Description : Four-digit multiplexed 7-segment driver with per-frame input
//               snapshot and per-slot dead time. Optional macro
//               LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_display
    import bcd_display_pkg::*;
#(
    parameter int DIV          = 12000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [6:0] SEG,
    output logic [3:0] DIGIT
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0][3:0]  r_snap;
    logic [6:0]       r_seg;
    logic [3:0]       r_digit;

    logic       w_slot_end;
    logic       w_frame_end;
    logic       w_dead;
    logic [3:0] w_lz;
    logic       w_blank;
    seg_t       w_seg;
    logic [3:0] w_onehot;

    assign w_slot_end  = (r_cnt == c_cnt_max);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);
    assign w_onehot    = 4'b0001 << r_idx;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            localparam logic [CNT_W-1:0] c_blank = CNT_W'(BLANK_CYCLES);
            assign w_dead = (r_cnt < c_blank);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero only if it and every digit to its left is 0;
    // codes above 9 count as non-zero, and units is always shown.
    always_comb begin
        w_lz    = 4'b0000;
        w_lz[3] = (r_snap[3] == 4'd0);
        w_lz[2] = w_lz[3] && (r_snap[2] == 4'd0);
        w_lz[1] = w_lz[2] && (r_snap[1] == 4'd0);
    end
`else
    assign w_lz = 4'b0000;
`endif

    assign w_blank = w_lz[r_idx];

    bcd_to_7seg u_dec (
        .bcd (r_snap[r_idx]),
        .seg (w_seg)
    );

    // Snapshot loads on the same edge the scan wraps back to digit 0, so the
    // new frame starts with coherent data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_snap  <= '0;
            r_seg   <= SEG_OFF;
            r_digit <= 4'b0000;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_frame_end) begin
                r_snap <= {thousands, hundreds, tens, units};
            end
            r_seg   <= w_blank ? SEG_OFF : w_seg;
            r_digit <= (w_dead || w_blank) ? 4'b0000 : w_onehot;
        end
    end

    assign SEG   = r_seg;
    assign DIGIT = r_digit;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// ============================================================================
// Module      : tb_bcd_scan_display
// Description : Self-checking bench for bcd_scan_display against a frame-level
//               reference model (DIV=8, BLANK_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_scan_display;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] units = '0, tens = '0, hundreds = '0, thousands = '0;
    logic [6:0] SEG;
    logic [3:0] DIGIT;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: edges since reset, and the digits latched for this frame.
    int m_n = 0;
    int m_snap [4];

    bcd_scan_display #(.DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .units     (units),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .SEG       (SEG),
        .DIGIT     (DIGIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit lead_blank(input int d);
        bit b;
        b = (d != 0);
        for (int k = 3; k >= d; k--) begin
            if (m_snap[k] != 0) b = 1'b0;
        end
        return b;
    endfunction

    // One clock: predict the outputs from the model, clock, then compare.
    task automatic tick();
        int pos, d, c;
        logic [6:0] es;
        logic [3:0] ed;
        if (RST) begin
            es  = 7'h00;
            ed  = 4'b0000;
            m_n = 0;
            for (int k = 0; k < 4; k++) m_snap[k] = 0;
        end else begin
            pos = m_n % FRAME;
            d   = pos / DIV;
            c   = pos % DIV;
            es  = SEG_TAB[m_snap[d]];
            ed  = (c < BLANK) ? 4'b0000 : 4'(1 << d);
`ifdef LEADING_ZERO_BLANK_EN
            if (lead_blank(d)) begin
                es = 7'h00;
                ed = 4'b0000;
            end
`endif
            if (pos == FRAME - 1) begin
                m_snap[0] = int'(units);
                m_snap[1] = int'(tens);
                m_snap[2] = int'(hundreds);
                m_snap[3] = int'(thousands);
            end
            m_n++;
        end
        @(posedge CLK);
        #1;
        chk("seg", SEG, es);
        chk("digit", {3'b000, DIGIT}, {3'b000, ed});
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    task automatic set_in(input int u, input int t, input int h, input int th);
        units     = 4'(u);
        tens      = 4'(t);
        hundreds  = 4'(h);
        thousands = 4'(th);
    endtask

    task automatic run_to_idx(input int d);
        for (int k = 0; k < FRAME && ((m_n % FRAME) / DIV) != d; k++) tick();
    endtask

    initial begin
        bit found;
        for (int k = 0; k < 4; k++) m_snap[k] = 0;

        // Reset held three cycles with random inputs.
        set_in($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
        RST = 1'b1;
        run(3);
        chk("reset_seg", SEG, 7'h00);
        chk("reset_digit", {3'b000, DIGIT}, 7'h00);
        RST = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (DIGIT == 4'b0001) found = 1'b1;
        end
        if (found) chk("first_lit_seg", SEG, 7'h3F);
        else       chk("first_lit_timeout", {3'b000, DIGIT}, 7'h01);

        // Scan and dead time: 1,2,3,4 held for two full frames.
        set_in(1, 2, 3, 4);
        run(2 * FRAME + DIV);

        // Units change mid-frame must wait for the next wrap.
        run_to_idx(2);
        units = 4'd9;
        run(2 * FRAME);

        // Invalid code on the leftmost digit.
        thousands = 4'hC;
        run(2 * FRAME);

        // Leading zeros.
        set_in(5, 0, 0, 0);
        run(2 * FRAME);
        set_in(0, 0, 0, 0);
        run(2 * FRAME);
        set_in(3, 0, 7, 0);
        run(2 * FRAME);

        // Reset mid-frame.
        set_in(8, 6, 4, 2);
        run(FRAME);
        run_to_idx(2);
        tick();
        RST = 1'b1;
        tick();
        chk("midreset_seg", SEG, 7'h00);
        chk("midreset_digit", {3'b000, DIGIT}, 7'h00);
        RST = 1'b0;
        run(2 * FRAME);

        // Randomized input changes at arbitrary points in the scan.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: units     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    1: tens      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    2: hundreds  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    default: thousands = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 299) == 0) RST = 1'b1;
            tick();
            RST = 1'b0;
        end
        run(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
